// File: rtl/stream_packer_pkg.sv
// ============================================================================
// Module      : stream_packer_pkg
// Description : Shared stream types (valid/ready beat) and count-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package stream_packer_pkg;

    // One side of a valid/ready handshake; a beat moves when both are high.
    typedef struct packed {
        logic valid;
        logic ready;
    } hs_t;

    localparam int C_MIN_RATIO = 2;

    // Width of a counter spanning 0..ratio-1.
    function automatic int cnt_width(input int ratio);
        return (ratio < C_MIN_RATIO) ? 1 : $clog2(ratio);
    endfunction

endpackage : stream_packer_pkg

`default_nettype wire

// File: rtl/stream_packer.sv
// ============================================================================
// Module      : stream_packer
// Description : Narrow-to-wide gearbox; packs RATIO WIDTH-bit words per output.
//               Define STREAM_PACKER_LAST_EN for IN_last / OUT_mask support.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_packer
    import stream_packer_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int RATIO = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     IN_valid,
    input  logic [WIDTH-1:0]         IN_data,
`ifdef STREAM_PACKER_LAST_EN
    input  logic                     IN_last,
`endif
    output logic                     OUT_ready,
    output logic                     OUT_valid,
    output logic [WIDTH*RATIO-1:0]   OUT_data,
`ifdef STREAM_PACKER_LAST_EN
    output logic [RATIO-1:0]         OUT_mask,
`endif
    input  logic                     IN_ready
);

    localparam int            CW        = cnt_width(RATIO);
    localparam logic [CW-1:0] C_CNT_MAX = CW'(RATIO - 1);

    logic [RATIO-2:0][WIDTH-1:0] r_acc;
    logic [CW-1:0]               r_cnt;
    logic                        r_out_valid;
    logic [WIDTH*RATIO-1:0]      r_out_data;

    hs_t                         w_in_hs;
    hs_t                         w_out_hs;
    logic                        w_complete_if;
    logic                        w_accept;
    logic                        w_complete;
    logic [WIDTH*RATIO-1:0]      w_packed;

`ifdef STREAM_PACKER_LAST_EN
    logic [RATIO-1:0]            r_out_mask;
    logic [RATIO-1:0]            w_mask;

    assign w_complete_if = (r_cnt == C_CNT_MAX) || IN_last;
    assign OUT_mask      = r_out_mask;
`else
    assign w_complete_if = (r_cnt == C_CNT_MAX);
`endif

    // Only a completing beat needs room in the output register.
    assign OUT_ready      = !w_complete_if || !r_out_valid || IN_ready;

    assign w_in_hs.valid  = IN_valid;
    assign w_in_hs.ready  = OUT_ready;
    assign w_out_hs.valid = r_out_valid;
    assign w_out_hs.ready = IN_ready;

    assign w_accept       = w_in_hs.valid && w_in_hs.ready;
    assign w_complete     = w_accept && w_complete_if;

    assign OUT_valid      = r_out_valid;
    assign OUT_data       = r_out_data;

    // Slot i takes the stored word below cnt, the live word at cnt, else zero.
    for (genvar i = 0; i < RATIO; i++) begin : g_slot
        if (i < RATIO - 1) begin : g_acc
            assign w_packed[i*WIDTH +: WIDTH] = (r_cnt >  CW'(i)) ? r_acc[i] :
                                                (r_cnt == CW'(i)) ? IN_data  : '0;
        end else begin : g_top
            assign w_packed[i*WIDTH +: WIDTH] = (r_cnt == CW'(i)) ? IN_data : '0;
        end
`ifdef STREAM_PACKER_LAST_EN
        if (i == 0) begin : g_mask0
            assign w_mask[i] = 1'b1;
        end else begin : g_maskn
            assign w_mask[i] = (r_cnt >= CW'(i));
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            if (w_accept) begin
                if (w_complete_if) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                    for (int i = 0; i < RATIO - 1; i++) begin
                        if (r_cnt == CW'(i)) begin
                            r_acc[i] <= IN_data;
                        end
                    end
                end
            end

            if (w_complete) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_packed;
            end else if (w_out_hs.valid && w_out_hs.ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

`ifdef STREAM_PACKER_LAST_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_mask <= '0;
        end else if (w_complete) begin
            r_out_mask <= w_mask;
        end
    end
`endif

endmodule : stream_packer

`default_nettype wire

// File: doc/stream_packer.md
# stream_packer

Narrow-to-wide stream gearbox on the read side of a FIFO. It consumes WIDTH-bit words through a valid/ready handshake and drives the FIFO's ready input from its own OUT_ready. It assembles RATIO consecutive words into one WIDTH*RATIO-bit word and presents that word downstream through a registered valid/ready output. It sustains one input word per cycle while downstream is ready.

## Interface
- WIDTH, 32, input word width in bits.
- RATIO, 4, input words per output word; must be ≥ 2 (not required to be a power of two).
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset, sampled on posedge clk.
- IN_valid  input  1  upstream word valid; connects to the FIFO's OUT_valid.
- IN_data  input  WIDTH  upstream word; connects to the FIFO's OUT_data.
- IN_last  input  1  final word of a group; only present when STREAM_PACKER_LAST_EN is defined.
- OUT_ready  output  WIDTH? no — 1  packer accepts the current word; connects to the FIFO's IN_ready.
- OUT_valid  output  1  packed word valid.
- OUT_data  output  WIDTH*RATIO  packed word; first accepted word in bits [WIDTH-1:0].
- OUT_mask  output  RATIO  per-word valid mask of OUT_data; only present when STREAM_PACKER_LAST_EN is defined.
- IN_ready  input  1  downstream accepts OUT_data.

## Operation
- State:
  - accumulator acc: RATIO-1 words.
  - count cnt: width $clog2(RATIO), range 0..RATIO-1.
  - output register: OUT_data, OUT_valid, OUT_mask.
- Beat accepted when IN_valid && OUT_ready.
- Completing beat: an accepted beat with cnt == RATIO-1, or with IN_last == 1 when the feature is enabled.
- Non-completing accepted beat:
  - acc[cnt] <= IN_data.
  - cnt <= cnt+1.
- Completing accepted beat:
  - OUT_data <= {IN_data, acc words cnt-1..0}. Slots above cnt are zero-filled.
  - OUT_mask <= bits 0..cnt set.
  - OUT_valid <= 1.
  - cnt <= 0.
- Output drain: OUT_valid && IN_ready with no completing beat in the same cycle gives OUT_valid <= 0.
- Simultaneous drain and completing beat: OUT_valid stays 1 and the output register takes the new word.
- Ready rule, combinational: OUT_ready = !completing_if_accepted || !OUT_valid || IN_ready.
  - Non-completing beats are never stalled by a full output register.
  - OUT_ready may depend on cnt, IN_last and IN_ready.
  - OUT_ready never depends on IN_valid.
- Hold rule: while OUT_valid && !IN_ready, OUT_data and OUT_mask are stable.
- Reset: OUT_valid=0, OUT_data=0, OUT_mask=0, cnt=0, acc=0.
  - A partial group in flight is discarded.
  - An undrained output word is dropped.
- cnt wrap: cnt returns to 0 only via a completing beat and never exceeds RATIO-1.

## Timing
- Latency: completing beat accepted in cycle N gives OUT_valid=1 and data visible in cycle N+1.
- Throughput: one input word per cycle indefinitely while IN_ready=1. No bubble between consecutive groups.
- Backpressure: with OUT_valid=1 and IN_ready=0, the packer keeps accepting up to RATIO-1 further words, then deasserts OUT_ready on the next completing beat until the drain.
- No combinational path from IN_data to any output.

## Configuration
- STREAM_PACKER_LAST_EN defined:
  - IN_last and OUT_mask ports exist.
  - Early group termination flushes a partial word, with zero-filled upper slots and the matching mask.
  - IN_last at cnt == RATIO-1 behaves identically to a normal completion.
- STREAM_PACKER_LAST_EN undefined:
  - Ports absent.
  - Only full groups of RATIO words are emitted.
  - OUT_ready = (cnt != RATIO-1) || !OUT_valid || IN_ready.

## Structure
- Shared stream package holds the valid/ready beat typedef convention and a localparam helper for count width, $clog2(RATIO).
- The packer itself has no typedefs of its own.
- Single flat module; no sub-module is natural.
- The testbench instantiates FIFO upstream, FIFO.OUT_* → stream_packer.IN_*, with stream_packer.OUT_ready → FIFO.IN_ready.

## Test plan
All scenarios use WIDTH=8, RATIO=4.
- Reset, then idle → OUT_valid=0, OUT_data=0, OUT_ready=1.
- Stream 0x11,0x22,0x33,0x44 back-to-back with IN_ready=1 → one cycle after the 0x44 beat, OUT_data=0x44332211, OUT_valid=1; continuous 8 words give two outputs on consecutive 4-cycle boundaries with no stall.
- Hold IN_ready=0 after the first packed output, then stream 0xA0..0xA3 → 0xA0..0xA2 accepted, OUT_ready=0 at the 0xA3 beat, OUT_data stays 0x44332211. Raise IN_ready → next cycle OUT_data=0xA3A2A1A0.
- LAST_EN: words 0x01,0x02 with IN_last on 0x02 → OUT_data=0x00000201, OUT_mask=4'b0011. The next group starts at slot 0.
- Assert rst after 2 words of a group, then send 0x55,0x66,0x77,0x88 → OUT_data=0x88776655. The earlier words never appear.
- Random IN_valid/IN_ready throttling over 1000 words against a reference model → every output equals four in-order inputs, with none lost or duplicated.
